writeback_unit: RTL and testbench
=================================

WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 Parameter XLEN, default 32: datapath width; only 32 is supported.
REQ-002 Parameter CNTW, default 64: width of the retired-instruction counter.
REQ-003 One clock; reset is synchronous and active-high; ports named clk and rst.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 stall  in  1  hold the MEM/WB stage register.
REQ-007 flush  in  1  load a bubble into the stage register; overrides stall.
REQ-008 mem_valid  in  1  MEM stage holds a real instruction.
REQ-009 mem_regWrite  in  1  instruction writes rd.
REQ-010 mem_rd  in  5  destination register index.
REQ-011 mem_resultSel  in  2  00 ALU, 01 load, 10 PC+4, 11 reserved (treated as ALU).
REQ-012 mem_funct3  in  3  load size/sign code.
REQ-013 mem_aluResult  in  XLEN  ALU result or load effective address.
REQ-014 mem_loadData  in  XLEN  aligned 32-bit word read from data memory.
REQ-015 mem_pcPlus4  in  XLEN  link value.
REQ-016 writeEn  out  1  register-file write enable.
REQ-017 addr3  out  5  register-file write index.
REQ-018 writeData  out  XLEN  register-file write data; also the forwarding value to EX.
REQ-019 instret  out  CNTW  count of retired instructions.

Function
REQ-020 On a rising edge with flush=1, the stage register SHALL capture valid=0; all other stage fields are don't-care.
REQ-021 On a rising edge with flush=0 and stall=1, the stage register SHALL hold its contents.
REQ-022 On a rising edge with flush=0 and stall=0, the stage register SHALL capture all mem_* inputs; latency from MEM inputs to the writeback outputs is 1 cycle.
REQ-023 writeEn SHALL equal wb_valid AND wb_regWrite AND (wb_rd != 0); writes to x0 are never issued.
REQ-024 addr3 SHALL equal wb_rd, and writeData SHALL be driven combinationally from the stage register.
REQ-025 Load extraction: offset = wb_aluResult[1:0]; byte = word[8*offset+7 : 8*offset]; half = word[16*offset[1]+15 : 16*offset[1]].
REQ-026 funct3 000 LB sign-extends byte; 100 LBU zero-extends byte; 001 LH sign-extends half; 101 LHU zero-extends half; 010 LW and all other codes pass the full word.
REQ-027 Misaligned halfword offsets (offset[0]=1) SHALL use offset[1] only; no trap is raised.
REQ-028 instret SHALL increment by 1 on each rising edge where wb_valid=1 and (stall=0 or flush=1); it wraps modulo 2^CNTW.
REQ-029 With stall=1 held across N cycles, writeEn SHALL remain asserted with the same addr3/writeData (idempotent rewrite), and instret SHALL not increment until release.

Reset
REQ-030 While rst=1 at a rising edge, wb_valid SHALL become 0 and instret SHALL become 0; rst overrides flush and stall.
REQ-031 After reset, writeEn=0, addr3=0 and writeData=0 until the first valid capture; stage data fields SHALL therefore reset to 0.
REQ-032 Reset asserted mid-stall SHALL discard the held instruction without counting it.

Structure
REQ-033 Package riscv_pkg SHALL hold the resultSel encodings (RES_ALU, RES_LOAD, RES_PC4) and the load funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU).
REQ-034 Combinational sub-module load_extend (inputs: word, offset, funct3; output: XLEN value) SHALL implement REQ-025..027.

Verification
REQ-035 Capture ALU op with rd=5, aluResult=0xDEADBEEF -> next cycle writeEn=1, addr3=5, writeData=0xDEADBEEF, instret=1 one edge later.
REQ-036 Load with word=0x80FF7F01: LB offset 2 -> 0xFFFFFFFF; LBU offset 3 -> 0x00000080; LH offset 2 -> 0xFFFF80FF; LHU offset 0 -> 0x00007F01.
REQ-037 rd=0, regWrite=1, valid=1 -> writeEn=0, instret still increments.
REQ-038 Stall for 3 cycles on a valid JAL (resultSel=10, pcPlus4=0x104, rd=1) -> writeData=0x104 held all 3 cycles; instret increments once after release.
REQ-039 Stall and flush asserted together -> stage becomes bubble (writeEn=0 next cycle); the held instruction is counted once.
REQ-040 Assert rst during a stall with valid held -> writeEn=0, writeData=0, instret=0 on the following cycle.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V encodings for the writeback stage: result-source selects and
// load funct3 codes.
package riscv_pkg;

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extend.sv
// Extracts the addressed byte/halfword from an aligned load word and sign- or
// zero-extends it according to funct3.
module load_extend
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] value
);

  logic [7:0]         byte_v;
  logic [15:0]        half_v;
  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  always_comb begin
    byte_v = word[7:0];
    case (offset)
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      2'd3:    byte_v = word[31:24];
      default: byte_v = word[7:0];
    endcase
  end

  // Misaligned halfwords ignore offset[0] and never trap.
  assign half_v = offset[1] ? word[31:16] : word[15:0];
  assign byte_s = byte_v;
  assign half_s = half_v;

  always_comb begin
    value = word;
    case (funct3)
      F3_LB:   value = XLEN'(byte_s);
      F3_LBU:  value = XLEN'(byte_v);
      F3_LH:   value = XLEN'(half_s);
      F3_LHU:  value = XLEN'(half_v);
      default: value = word;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// MEM/WB stage register plus writeback result selection, register-file write
// control and the retired-instruction counter.
module writeback_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int CNTW = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            mem_valid,
  input  logic            mem_regWrite,
  input  logic [4:0]      mem_rd,
  input  logic [1:0]      mem_resultSel,
  input  logic [2:0]      mem_funct3,
  input  logic [XLEN-1:0] mem_aluResult,
  input  logic [XLEN-1:0] mem_loadData,
  input  logic [XLEN-1:0] mem_pcPlus4,
  output logic            writeEn,
  output logic [4:0]      addr3,
  output logic [XLEN-1:0] writeData,
  output logic [CNTW-1:0] instret
);

  logic            vld_p1;
  logic            regwrite_p1;
  logic [4:0]      rd_p1;
  logic [1:0]      sel_p1;
  logic [2:0]      f3_p1;
  logic [XLEN-1:0] alu_p1;
  logic [XLEN-1:0] ld_p1;
  logic [XLEN-1:0] pc4_p1;
  logic [XLEN-1:0] load_val;

  // MEM -> WB boundary; data fields clear on reset so outputs read zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      regwrite_p1 <= 1'b0;
      rd_p1       <= '0;
      sel_p1      <= '0;
      f3_p1       <= '0;
      alu_p1      <= '0;
      ld_p1       <= '0;
      pc4_p1      <= '0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (!stall) begin
      vld_p1      <= mem_valid;
      regwrite_p1 <= mem_regWrite;
      rd_p1       <= mem_rd;
      sel_p1      <= mem_resultSel;
      f3_p1       <= mem_funct3;
      alu_p1      <= mem_aluResult;
      ld_p1       <= mem_loadData;
      pc4_p1      <= mem_pcPlus4;
    end
  end

  // An instruction retires when it leaves the stage, by advance or by flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      instret <= '0;
    end else if (vld_p1 && (!stall || flush)) begin
      instret <= instret + CNTW'(1);
    end
  end

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .word   (ld_p1),
    .offset (alu_p1[1:0]),
    .funct3 (f3_p1),
    .value  (load_val)
  );

  always_comb begin
    writeData = alu_p1;
    case (sel_p1)
      RES_LOAD: writeData = load_val;
      RES_PC4:  writeData = pc4_p1;
      default:  writeData = alu_p1;
    endcase
  end

  assign writeEn = vld_p1 & regwrite_p1 & (rd_p1 != 5'd0);
  assign addr3   = rd_p1;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: vector table for the capture/select/extend
// paths plus hand sequences for stall, stall+flush and reset-during-stall.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic        mem_valid, mem_regWrite;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_resultSel;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_aluResult, mem_loadData, mem_pcPlus4;
  logic        writeEn;
  logic [4:0]  addr3;
  logic [31:0] writeData;
  logic [63:0] instret;

  writeback_unit #(.XLEN(32), .CNTW(64)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_regWrite(mem_regWrite), .mem_rd(mem_rd),
    .mem_resultSel(mem_resultSel), .mem_funct3(mem_funct3),
    .mem_aluResult(mem_aluResult), .mem_loadData(mem_loadData),
    .mem_pcPlus4(mem_pcPlus4),
    .writeEn(writeEn), .addr3(addr3), .writeData(writeData), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic        rw;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] ld;
    logic [31:0] pc4;
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];
  vec_t jal;

  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_cnt = '0;
  logic        mdl_vld = 1'b0;
  logic [63:0] cnt_before;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t t);
    mem_valid     = t.v;
    mem_regWrite  = t.rw;
    mem_rd        = t.rd;
    mem_resultSel = t.sel;
    mem_funct3    = t.f3;
    mem_aluResult = t.alu;
    mem_loadData  = t.ld;
    mem_pcPlus4   = t.pc4;
  endtask

  // Spec-level retire model: advance or flush retires the stage occupant.
  task automatic tick();
    if (rst) begin
      exp_cnt = '0;
      mdl_vld = 1'b0;
    end else begin
      if (mdl_vld && (!stall || flush)) exp_cnt = exp_cnt + 64'd1;
      if (flush)       mdl_vld = 1'b0;
      else if (!stall) mdl_vld = mem_valid;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic we, input logic [4:0] a3,
                         input logic [31:0] wd);
    chk({name, ".writeEn"},   64'(writeEn),   64'(we));
    chk({name, ".addr3"},     64'(addr3),     64'(a3));
    chk({name, ".writeData"}, 64'(writeData), 64'(wd));
  endtask

  initial begin
    //          v  rw rd     sel    f3      alu           ld            pc4           we a3     wd
    vecs[0]  = '{1'b1,1'b1,5'd5, 2'b00,3'b000,32'hDEADBEEF,32'h0,       32'h0,       1'b1,5'd5, 32'hDEADBEEF};
    vecs[1]  = '{1'b1,1'b1,5'd3, 2'b01,3'b000,32'h00001002,32'h80FF7F01,32'h0,       1'b1,5'd3, 32'hFFFFFFFF};
    vecs[2]  = '{1'b1,1'b1,5'd4, 2'b01,3'b100,32'h00001003,32'h80FF7F01,32'h0,       1'b1,5'd4, 32'h00000080};
    vecs[3]  = '{1'b1,1'b1,5'd6, 2'b01,3'b001,32'h00001002,32'h80FF7F01,32'h0,       1'b1,5'd6, 32'hFFFF80FF};
    vecs[4]  = '{1'b1,1'b1,5'd7, 2'b01,3'b101,32'h00001000,32'h80FF7F01,32'h0,       1'b1,5'd7, 32'h00007F01};
    vecs[5]  = '{1'b1,1'b1,5'd8, 2'b01,3'b000,32'h00001000,32'h80FF7F01,32'h0,       1'b1,5'd8, 32'h00000001};
    vecs[6]  = '{1'b1,1'b1,5'd9, 2'b01,3'b001,32'h00001003,32'h80FF7F01,32'h0,       1'b1,5'd9, 32'hFFFF80FF};
    vecs[7]  = '{1'b1,1'b1,5'd10,2'b01,3'b101,32'h00001001,32'h80FF7F01,32'h0,       1'b1,5'd10,32'h00007F01};
    vecs[8]  = '{1'b1,1'b1,5'd11,2'b01,3'b010,32'h00001002,32'h80FF7F01,32'h0,       1'b1,5'd11,32'h80FF7F01};
    vecs[9]  = '{1'b1,1'b1,5'd12,2'b01,3'b110,32'h00001001,32'h80FF7F01,32'h0,       1'b1,5'd12,32'h80FF7F01};
    vecs[10] = '{1'b1,1'b1,5'd0, 2'b00,3'b000,32'h00000055,32'h0,       32'h0,       1'b0,5'd0, 32'h00000055};
    vecs[11] = '{1'b0,1'b1,5'd13,2'b00,3'b000,32'h00000077,32'h0,       32'h0,       1'b0,5'd13,32'h00000077};
    vecs[12] = '{1'b1,1'b0,5'd14,2'b00,3'b000,32'h00000099,32'h0,       32'h0,       1'b0,5'd14,32'h00000099};
    vecs[13] = '{1'b1,1'b1,5'd15,2'b11,3'b000,32'h12345678,32'hAAAAAAAA,32'hBBBBBBBB,1'b1,5'd15,32'h12345678};
    vecs[14] = '{1'b1,1'b1,5'd31,2'b10,3'b000,32'h12345678,32'hAAAAAAAA,32'h00000200,1'b1,5'd31,32'h00000200};
    jal      = '{1'b1,1'b1,5'd1, 2'b10,3'b000,32'h00000F00,32'h0,       32'h00000104,1'b1,5'd1, 32'h00000104};

    // Reset with busy inputs: reset must win over capture.
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    apply(vecs[0]);
    tick();
    tick();
    rst = 1'b0;
    mem_valid = 1'b0;
    chk_out("reset", 1'b0, 5'd0, 32'h0);
    chk("reset.instret", instret, 64'd0);

    for (int i = 0; i < NVEC; i++) begin
      apply(vecs[i]);
      tick();
      chk_out($sformatf("vec%0d", i), vecs[i].we, vecs[i].a3, vecs[i].wd);
      chk($sformatf("vec%0d.instret", i), instret, exp_cnt);
    end

    // JAL held by a 3-cycle stall while MEM presents another instruction.
    apply(jal);
    tick();
    chk_out("jal", 1'b1, 5'd1, 32'h104);
    cnt_before = instret;
    stall = 1'b1;
    apply(vecs[0]);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_out($sformatf("jal_stall%0d", c), 1'b1, 5'd1, 32'h104);
      chk($sformatf("jal_stall%0d.instret", c), instret, cnt_before);
    end
    stall = 1'b0;
    tick();
    chk("jal_release.instret", instret, cnt_before + 64'd1);
    chk_out("jal_release", 1'b1, 5'd5, 32'hDEADBEEF);

    // Stall and flush together: bubble in, held instruction counted once.
    cnt_before = instret;
    stall = 1'b1; flush = 1'b1;
    apply(vecs[5]);
    tick();
    chk("stallflush.writeEn", 64'(writeEn), 64'd0);
    chk("stallflush.instret", instret, cnt_before + 64'd1);
    stall = 1'b0; flush = 1'b0;
    mem_valid = 1'b0;
    tick();
    chk("stallflush_after.instret", instret, cnt_before + 64'd1);
    chk("stallflush_model.instret", instret, exp_cnt);

    // Reset during a stall discards the held instruction uncounted.
    apply(jal);
    tick();
    stall = 1'b1;
    tick();
    chk("rststall_held.writeEn", 64'(writeEn), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_out("rststall", 1'b0, 5'd0, 32'h0);
    chk("rststall.instret", instret, 64'd0);
    stall = 1'b0;
    mem_valid = 1'b0;
    tick();
    chk("rststall_after.instret", instret, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
